// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU / front-panel memory path.
// Mode values, arbiter state type and default bus widths.
package cpu_pkg;

  localparam int CPU_AW = 16;
  localparam int CPU_DW = 8;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_WR,
    S_CPU_RD,
    S_PNL_WR,
    S_PNL_RD,
    S_ACK
  } arb_state_t;

endpackage

// File: rtl/panel_key_sync.sv
// Panel key synchronizer and rising-edge pulse generator.
// Optional debounce filter enabled by MEM_ARBITER_DEBOUNCE_EN.
module panel_key_sync #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic A1,
  output logic evt
);

  logic s1, s2, lvl, lvl_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= A1;
      s2 <= s1;
    end
  end

`ifdef MEM_ARBITER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          filt;
  logic [CW-1:0] cnt;

  // Level flips only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign lvl = filt;
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign lvl = s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) lvl_q <= 1'b0;
    else      lvl_q <= lvl;
  end

  assign evt = lvl & ~lvl_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the RAM port between the CPU bus and the panel loader.
// A1 debounce is compiled in with MEM_ARBITER_DEBOUNCE_EN.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW        = CPU_AW,
  parameter int DW        = CPU_DW,
  parameter int PAW       = 8,
  parameter int RD_LAT    = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     mode,
  input  logic           A1,
  input  logic [DW-1:0]  D,
  input  logic           cpu_read,
  input  logic           cpu_write,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic [DW-1:0]  cpu_rdata,
  output logic           cpu_ack,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [DW-1:0]  mem_rdata,
  output logic [DW-1:0]  check_out,
  output logic [PAW-1:0] panel_addr,
  output logic           busy
);

  arb_state_t state;
  logic       evt, pending, pnl_hold;
  logic [1:0] mode_q, rd_cnt;
  logic       mode_chg, rd_last;
  logic       go_cwr, go_crd, go_pwr, go_prd;

  panel_key_sync #(.DB_CYCLES(DB_CYCLES)) u_key (
    .clk (clk),
    .rst (rst),
    .A1  (A1),
    .evt (evt)
  );

  assign mode_chg = (mode != mode_q);
  assign rd_last  = (rd_cnt == 2'(RD_LAT - 1));
  assign busy     = (state != S_IDLE);

  // Panel grants wait out a mode-change cycle, which drops pending
  assign go_cwr = (mode == MODE_RUN) & cpu_write;
  assign go_crd = (mode == MODE_RUN) & cpu_read & ~cpu_write;
  assign go_pwr = (mode == MODE_LOAD) & pending & ~mode_chg;
  assign go_prd = (mode == MODE_CHECK) & pending & ~mode_chg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      pnl_hold   <= 1'b0;
      mode_q     <= MODE_STOP;
      rd_cnt     <= '0;
      panel_addr <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      check_out  <= '0;
    end else begin
      mode_q  <= mode;
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      cpu_ack <= 1'b0;
      if (evt) pending <= 1'b1;
      if (mode_chg) begin
        pending    <= 1'b0;
        panel_addr <= '0;
      end
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            go_cwr: begin
              state     <= S_CPU_WR;
              mem_we    <= 1'b1;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            go_crd: begin
              state    <= S_CPU_RD;
              mem_re   <= 1'b1;
              mem_addr <= cpu_addr;
              rd_cnt   <= '0;
            end
            go_pwr: begin
              state     <= S_PNL_WR;
              mem_we    <= 1'b1;
              mem_addr  <= AW'(panel_addr);
              mem_wdata <= D;
              pending   <= 1'b0;
              pnl_hold  <= 1'b0;
            end
            go_prd: begin
              state    <= S_PNL_RD;
              mem_re   <= 1'b1;
              mem_addr <= AW'(panel_addr);
              rd_cnt   <= '0;
              pending  <= 1'b0;
              pnl_hold <= 1'b0;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_CPU_WR: begin
          state   <= S_ACK;
          cpu_ack <= 1'b1;
        end
        S_CPU_RD: begin
          if (rd_last) begin
            cpu_rdata <= mem_rdata;
            cpu_ack   <= 1'b1;
            state     <= S_ACK;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
            mem_re <= 1'b1;
          end
        end
        S_PNL_WR: begin
          state <= S_IDLE;
          if (!mode_chg) panel_addr <= panel_addr + PAW'(1);
        end
        S_PNL_RD: begin
          if (rd_last) begin
            check_out <= mem_rdata;
            state     <= S_IDLE;
            if (!mode_chg && !pnl_hold)
              panel_addr <= panel_addr + PAW'(1);
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
            mem_re <= 1'b1;
            if (mode_chg) pnl_hold <= 1'b1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model.
// Press timing adapts when MEM_ARBITER_DEBOUNCE_EN is defined.
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam int RD_LAT = 1;
`ifdef MEM_ARBITER_DEBOUNCE_EN
  localparam int PRESS_HI = 24;
  localparam int PRESS_LO = 24;
`else
  localparam int PRESS_HI = 4;
  localparam int PRESS_LO = 8;
`endif

  logic        clk = 0;
  logic        rst;
  logic [1:0]  mode;
  logic        A1;
  logic [7:0]  D;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [7:0]  check_out, panel_addr;
  logic        busy;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .mode(mode), .A1(A1), .D(D),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .check_out(check_out), .panel_addr(panel_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: unwritten locations return a fixed address pattern
  bit [7:0]   ram [65536];
  bit         wv  [65536];
  logic [7:0] mdl [65536];

  function automatic logic [7:0] bg(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign mem_rdata = wv[mem_addr] ? ram[mem_addr] : bg(mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wv[mem_addr]  <= 1'b1;
    end
  end

  int          we_cnt = 0, re_cnt = 0, ack_cnt = 0;
  logic [15:0] last_we_addr;
  logic [7:0]  last_we_data;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
    if (mem_re) re_cnt++;
    if (cpu_ack) ack_cnt++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pa;

  task automatic press(input logic [7:0] d);
    D  = d;
    A1 = 1'b1;
    repeat (PRESS_HI) @(posedge clk);
    #1 A1 = 1'b0;
    repeat (PRESS_LO) @(posedge clk);
    #1;
  endtask

  task automatic load_press(input logic [7:0] d);
    int w0;
    w0 = we_cnt;
    press(d);
    chk("ld_we", we_cnt - w0, 1);
    chk("ld_addr", last_we_addr, {8'h00, pa});
    chk("ld_data", last_we_data, d);
    mdl[{8'h00, pa}] = d;
    pa = pa + 8'd1;
    chk("ld_pa", panel_addr, pa);
  endtask

  task automatic check_press();
    int r0;
    r0 = re_cnt;
    press(8'h00);
    chk("ck_re", re_cnt - r0, RD_LAT);
    chk("ck_out", check_out, mdl[{8'h00, pa}]);
    pa = pa + 8'd1;
    chk("ck_pa", panel_addr, pa);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    pa   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cpu_txn(input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] wd);
    int w0, r0, k0, lat;
    bit seen;
    logic [7:0] rdv;
    w0 = we_cnt; r0 = re_cnt; k0 = ack_cnt;
    cpu_addr = a; cpu_wdata = wd;
    cpu_read = rd; cpu_write = wr;
    seen = 0; lat = -1; rdv = 8'h00;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        seen = 1;
        lat  = k;
        rdv  = cpu_rdata;
      end
    end
    cpu_read = 0; cpu_write = 0;
    @(posedge clk);
    #1;
    chk("cpu_ack_seen", seen, 1);
    chk("cpu_ack_cnt", ack_cnt - k0, 1);
    if (wr) begin
      mdl[a] = wd;
      chk("cpu_wr_lat", lat, 2);
      chk("cpu_wr_we", we_cnt - w0, 1);
      chk("cpu_wr_re", re_cnt - r0, 0);
      chk("cpu_wr_addr", last_we_addr, a);
      chk("cpu_wr_ram", ram[a], wd);
    end else begin
      chk("cpu_rd_lat", lat, RD_LAT + 1);
      chk("cpu_rd_re", re_cnt - r0, RD_LAT);
      chk("cpu_rd_we", we_cnt - w0, 0);
      chk("cpu_rd_data", rdv, mdl[a]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          w0, k0, op;
  bit          hit, seen;
  logic [15:0] a;
  logic [7:0]  d;

  initial begin
    for (int i = 0; i < 65536; i++) mdl[i] = bg(16'(i));
    rst = 0; mode = MODE_STOP; A1 = 0; D = 0;
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    pa = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_chk", check_out, 0);
    chk("rst_pa", panel_addr, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    @(posedge clk);
    #1;

    // LOAD: first press, then fill up to the wrap point
    set_mode(MODE_LOAD);
    load_press(8'h3C);
    while (pa != 8'hFF) load_press(8'($urandom));
    load_press(8'h5A);
    chk("wrap_pa", panel_addr, 8'h00);

`ifdef MEM_ARBITER_DEBOUNCE_EN
    w0 = we_cnt;
    A1 = 1;
    repeat (5) @(posedge clk);
    #1 A1 = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_we", we_cnt - w0, 0);
    chk("glitch_pa", panel_addr, 0);
`endif

    // CHECK: read back, then switch mode mid-read at address 3
    set_mode(MODE_CHECK);
    repeat (3) check_press();
    w0 = we_cnt;
    hit = 0;
    A1 = 1;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (k == PRESS_HI) A1 = 0;
      if (mem_re) begin
        mode = MODE_LOAD;
        hit  = 1;
      end
    end
    A1 = 0;
    repeat (PRESS_LO + 10) @(posedge clk);
    #1;
    pa = 8'h00;
    chk("mc_hit", hit, 1);
    chk("mc_chk", check_out, mdl[16'h0003]);
    chk("mc_pa", panel_addr, 0);
    chk("mc_we", we_cnt - w0, 0);

    // Press during STOP is dropped by the following mode change
    set_mode(MODE_STOP);
    w0 = we_cnt;
    press(8'h77);
    set_mode(MODE_LOAD);
    repeat (10) @(posedge clk);
    #1;
    chk("stop_pend_we", we_cnt - w0, 0);
    chk("stop_pend_pa", panel_addr, 0);

    // RUN: directed then random CPU traffic
    set_mode(MODE_RUN);
    cpu_txn(0, 1, 16'h0012, 8'hA7);
    cpu_txn(1, 0, 16'h0012, 8'h00);
    cpu_txn(1, 1, 16'h0040, 8'h11);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31))
                                        : 16'($urandom);
      d  = 8'($urandom);
      cpu_txn(op != 1, op != 0, a, d);
    end

    // STOP stalls a held CPU write until RUN
    set_mode(MODE_STOP);
    w0 = we_cnt; k0 = ack_cnt;
    a = 16'h0345; d = 8'($urandom);
    cpu_addr = a; cpu_wdata = d; cpu_write = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("stop_we", we_cnt - w0, 0);
    chk("stop_ack", ack_cnt - k0, 0);
    chk("stop_busy", busy, 0);
    mode = MODE_RUN;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (cpu_ack) seen = 1;
    end
    cpu_write = 0;
    @(posedge clk);
    #1;
    chk("stop_run_ack", seen, 1);
    chk("stop_run_we", we_cnt - w0, 1);
    chk("stop_run_ram", ram[a], d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single RAM port and shares it between the CPU bus master and the front-panel loader (switches D, key A1).
- In RUN mode the CPU is granted the port through a request/acknowledge handshake.
- In LOAD mode each A1 press writes D to a self-incrementing panel address; in CHECK mode each press reads one location back to check_out.
- Sits between cpu/CPU_Controller and ram in top; replaces the direct CPU-to-RAM wiring.

Parameters:
- AW, 16, memory address width
- DW, 8, data width
- PAW, 8, panel address counter width; upper AW-PAW address bits are driven 0 in panel accesses
- RD_LAT, 1, RAM read latency in clk cycles (1..3)
- DB_CYCLES, 16, A1 debounce stability window in cycles (used only with debounce compiled in)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- mode  in  2  cpustate from CPU_Controller: 00 STOP, 01 LOAD, 10 CHECK, 11 RUN
- A1  in  1  raw panel key, asynchronous to clk
- D  in  DW  panel data switches
- cpu_read  in  1  CPU read request, held until cpu_ack
- cpu_write  in  1  CPU write request, held until cpu_ack
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  registered read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_we  out  1  RAM write strobe
- mem_re  out  1  RAM read strobe
- mem_rdata  in  DW  RAM read data
- check_out  out  DW  last panel read value
- panel_addr  out  PAW  current panel address, for display
- busy  out  1  FSM not in S_IDLE

Behaviour:
- Reset (rst=0 at a clk edge): every output 0; FSM to S_IDLE; panel_addr 0; pending flag cleared; mode_q set to 00. Any in-flight access is aborted and strobes are low after that edge.
- A1 path:
  - 2-flop synchronizer, then rising-edge detect gives a 1-cycle evt.
  - evt sets a pending flag; it is cleared when the panel access is accepted.
  - Extra evts while pending is set are dropped.
- FSM states: S_IDLE, S_CPU_WR, S_CPU_RD, S_PNL_WR, S_PNL_RD, S_ACK.
- S_IDLE dispatch, evaluated against the current mode:
  - RUN and cpu_write goes to S_CPU_WR. Write wins if cpu_read and cpu_write are both asserted.
  - RUN and cpu_read goes to S_CPU_RD.
  - LOAD and pending goes to S_PNL_WR.
  - CHECK and pending goes to S_PNL_RD.
  - STOP: nothing is granted. CPU requests stall with no ack, and the pending flag is kept.
- S_CPU_WR / S_PNL_WR:
  - mem_we=1 for exactly 1 cycle.
  - CPU write: mem_addr=cpu_addr, mem_wdata=cpu_wdata, then S_ACK.
  - Panel write: mem_addr={0,panel_addr}, mem_wdata=D sampled on entry; panel_addr++ on exit; back to S_IDLE.
- S_CPU_RD / S_PNL_RD:
  - mem_re=1 for RD_LAT cycles.
  - mem_rdata is captured on the last cycle into cpu_rdata (CPU) or check_out (panel).
  - Panel read: panel_addr++ on exit, then S_IDLE. CPU read: S_ACK.
- S_ACK: cpu_ack=1 for one cycle, then S_IDLE. The CPU must drop its request in the cycle after ack; a request still asserted in S_IDLE is treated as a new access.
- Latency from request seen in S_IDLE:
  - CPU write: ack 2 cycles later.
  - CPU read: ack RD_LAT+1 cycles later.
  - Panel write to next dispatch: 2 cycles.
- Wrap: panel_addr 2^PAW-1 increments to 0 with no flag.
- Mode change (mode != mode_q):
  - pending is cleared.
  - panel_addr is set to 0. If a panel access is in flight, it completes at its old address and its increment is suppressed.
  - An in-flight CPU access always completes and acks.
  - mode_q updates every cycle.
- Outside active states, mem_addr/mem_wdata hold their last values; mem_we and mem_re are 0.

Optional Feature:
- Macro: MEM_ARBITER_DEBOUNCE_EN.
- Defined: the synchronized A1 must be stable for DB_CYCLES consecutive cycles before the filtered level changes. Edge detect runs on the filtered level, so presses shorter than DB_CYCLES produce no evt.
- Undefined: edge detect runs directly on the synchronizer output and DB_CYCLES is unused.

Decomposition:
- Shared package cpu_pkg holds:
  - mode encodings MODE_STOP/LOAD/CHECK/RUN
  - the FSM state enum type
  - default widths AW/DW
- Sub-module panel_key_sync: synchronizer, optional debounce and rising-edge pulse generator. Ports clk, rst, A1, evt.

Test Plan:
- Reset then mode=LOAD, D=8'h3C, one A1 press -> one mem_we pulse with mem_addr=16'h0000 and mem_wdata=8'h3C; panel_addr=1.
- mode=LOAD, panel_addr=8'hFF, A1 press with D=8'h5A -> write to 16'h00FF; panel_addr=8'h00.
- mode=RUN, RD_LAT=1, cpu_read with cpu_addr=16'h0012, RAM holds 8'hA7 -> mem_re one cycle; cpu_ack 2 cycles after request with cpu_rdata=8'hA7.
- mode=RUN, cpu_read and cpu_write both high, cpu_wdata=8'h11 -> write only; no mem_re; single ack.
- mode=STOP, cpu_write held 20 cycles -> no mem_we and no ack; switch to RUN -> write and ack complete.
- mode=CHECK, panel_addr=3, A1 press, then mode changes to LOAD during S_PNL_RD -> check_out=mem[3]; panel_addr=0 afterwards; pending cleared. With MEM_ARBITER_DEBOUNCE_EN defined, a 5-cycle A1 glitch produces no access.
